usb_ep_buf_rdr: RTL and testbench
=================================

USB_EP_BUF_RDR -- requirements
Module: usb_ep_buf_rdr

Interface
REQ-001 SHALL have parameter AWIDTH, default 11: byte address width of the endpoint buffer read port.
REQ-002 SHALL have parameter LWIDTH, default 11: packet length width in bytes; range 0..2^LWIDTH-1.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_addr, input, AWIDTH: buffer start address.
REQ-006 SHALL have port cmd_len, input, LWIDTH: payload byte count.
REQ-007 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-008 SHALL have ports buf_rd_addr_0 (output, AWIDTH) and buf_rd_en_0 (output, 1): buffer read request.
REQ-009 SHALL have port buf_rd_data_1, input, 8: buffer read data, valid 1 cycle after buf_rd_en_0.
REQ-010 SHALL have ports out_data (output, 8), out_last (output, 1), out_valid (output, 1) and out_ready (input, 1): byte stream to the transmitter.
REQ-011 SHALL have port abort, input, 1: abandons the current packet.
REQ-012 SHALL have port busy, output, 1: high from command accept until the last byte is taken.

Function
REQ-013 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
REQ-014 SHALL implement states IDLE -> FETCH -> DRAIN -> IDLE, with CRC0 -> CRC1 inserted before IDLE per REQ-026.
- FETCH: issue reads.
- DRAIN: all reads issued, waiting for the FIFO to empty.
REQ-015 SHALL issue the first read in the cycle after command accept; first out_valid no earlier than 2 cycles after accept.
REQ-016 SHALL increment the read address by 1 per issued read, wrapping modulo 2^AWIDTH (0x7FF -> 0x000 at default).
REQ-017 SHALL capture buf_rd_data_1 into a 2-entry output FIFO; assert buf_rd_en_0 only when FIFO occupancy plus in-flight reads is below 2.
REQ-018 SHALL sustain 1 byte/cycle with out_ready held high.
REQ-019 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-020 SHALL never drop or duplicate bytes under any out_ready pattern.
REQ-021 SHALL assert out_last on the final byte of the packet: the final payload byte, or CRC1 when CRC is enabled.
REQ-022 SHALL, for cmd_len == 0 without CRC, emit no bytes; busy high for 1 cycle, then IDLE.
REQ-023 SHALL, on abort, enter IDLE on the next edge: FIFO flushed, out_valid=0, buf_rd_en_0=0, any in-flight read data discarded.
- abort has priority over out_ready and over command accept in the same cycle.

Reset
REQ-024 SHALL, during reset, hold state=IDLE, FIFO empty, cmd_ready=1 after release, busy=0, out_valid=0, out_last=0, out_data=0x00, buf_rd_en_0=0, buf_rd_addr_0=0.
REQ-025 SHALL, on reset asserted mid-packet, clear everything immediately (asynchronously) with no further output.

Configuration
REQ-026 SHALL, when macro USB_EP_BUF_RDR_CRC_EN is defined, append CRC16 after the payload.
- CRC16 per USB: polynomial 0x8005, init 0xFFFF, reflected, output inverted.
- Computed over bytes as they enter the FIFO.
- Sent low byte then high byte via states CRC0 and CRC1.
- cmd_len == 0 emits 0x00, 0x00.
REQ-027 SHALL, when USB_EP_BUF_RDR_CRC_EN is undefined, contain no CRC logic or CRC states; out_last then marks the last payload byte.

Structure
REQ-028 SHALL place state encodings and the CRC16 polynomial/init constants in shared package usb_ep_buf_rdr_pkg.
REQ-029 SHALL instantiate sub-module usb_crc16 (byte-wide, 1-cycle update) only under USB_EP_BUF_RDR_CRC_EN.

Verification
REQ-030 SHALL cover basic read: buffer[0x010..0x012]=0x11,0x22,0x33, cmd_addr=0x010, cmd_len=3, out_ready=1, no CRC -> out 0x11,0x22,0x33, out_last on 0x33, first out_valid 2 cycles after accept.
REQ-031 SHALL cover backpressure: cmd_len=64 with out_ready random 50% -> 64 bytes in order, no duplicates, buf_rd_en_0 never asserted with occupancy+in-flight=2.
REQ-032 SHALL cover wrap: cmd_addr=0x7FF, cmd_len=2 -> reads at 0x7FF then 0x000, bytes output in that order.
REQ-033 SHALL cover ZLP: cmd_len=0 -> no CRC: no out_valid, cmd_ready high again 1 cycle later; CRC: 0x00, 0x00 with out_last on the second.
REQ-034 SHALL cover CRC: payload 0x00,0x01,0x02,0x03 with CRC -> output 0x00,0x01,0x02,0x03,0x5E,0xF7, out_last on 0xF7.
REQ-035 SHALL cover abort/reset mid-packet: abort (or rst_n low) after 5 of 20 bytes with out_ready=0 -> out_valid low next cycle, IDLE, next command (len=1) outputs its byte correctly.

Source files
------------

// File: rtl/usb_ep_buf_rdr_pkg.sv
// Shared definitions for the USB endpoint buffer reader.
//   - FSM state encoding (the CRC states exist only when USB_EP_BUF_RDR_CRC_EN is defined)
//   - USB CRC16 constants and the byte-wide update function used by usb_crc16
//   - output FIFO depth
package usb_ep_buf_rdr_pkg;

  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  // Bit-reversed 0x8005. USB sends bytes LSB first, so the register shifts right.
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  localparam logic [1:0]  FIFO_DEPTH      = 2'd2;

`ifdef USB_EP_BUF_RDR_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CRC0,
    S_CRC1
  } state_t;

  // One byte of reflected CRC16, processed LSB first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;
`endif

endpackage

// File: rtl/usb_ep_buf_rdr_if.sv
// Command and byte-stream bundle of the endpoint buffer reader.
//   cmd_*  : packet command (start address, length, valid/ready)
//   out_*  : byte stream to the transmitter (data, last, valid/ready)
// Modports: master = command issuer / stream consumer, slave = the reader.
interface usb_ep_buf_rdr_if #(
  parameter int AWIDTH = 11,
  parameter int LWIDTH = 11
);
  logic [AWIDTH-1:0] cmd_addr;
  logic [LWIDTH-1:0] cmd_len;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output cmd_addr, cmd_len, cmd_valid, out_ready,
    input  cmd_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  cmd_addr, cmd_len, cmd_valid, out_ready,
    output cmd_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/usb_ep_buf_rdr_crc.sv
// usb_crc16: byte-wide USB CRC16 register, one byte per cycle.
//   clk, rst_n : clock, async active-low reset
//   init       : reload CRC16_INIT (start of packet)
//   en, data   : fold one byte into the running CRC
//   crc        : raw (non-inverted) register value
module usb_crc16
  import usb_ep_buf_rdr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_next(crc, data);
    end
  end

endmodule

// File: rtl/usb_ep_buf_rdr.sv
// usb_ep_buf_rdr: reads a packet out of the endpoint buffer and streams it
// byte by byte to the transmitter through a 2-entry output FIFO.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : cmd_addr/cmd_len/cmd_valid/cmd_ready command,
//                         out_data/out_last/out_valid/out_ready byte stream
//   buf_rd_addr_0/en_0  : buffer read request; data returns on buf_rd_data_1 one cycle later
//   abort               : drop the current packet, back to IDLE on the next edge
//   busy                : high from command accept until the last byte is taken
// Optional feature: define USB_EP_BUF_RDR_CRC_EN to append the USB CRC16
// (low byte, then high byte carrying out_last) after the payload.
module usb_ep_buf_rdr
  import usb_ep_buf_rdr_pkg::*;
#(
  parameter int AWIDTH = 11,
  parameter int LWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  usb_ep_buf_rdr_if.slave   bus,
  output logic [AWIDTH-1:0] buf_rd_addr_0,
  output logic              buf_rd_en_0,
  input  logic [7:0]        buf_rd_data_1,
  input  logic              abort,
  output logic              busy
);

  state_t            state;
  logic [LWIDTH-1:0] rem;        // reads still to issue
  logic              inflight;   // a read was issued last cycle; its data is on buf_rd_data_1
  logic [1:0]        count;      // FIFO occupancy
  logic [7:0]        head_data, tail_data;
  logic              head_last, tail_last;

  logic              accept, pop, room, drain_done;
  logic [1:0]        level;
  logic              push, push_last;
  logic [7:0]        push_data;

`ifdef USB_EP_BUF_RDR_CRC_EN
  logic              tail_pushed;  // CRC high byte already sits in the FIFO
  logic [15:0]       crc_q, crc_out;
`else
  logic              inflight_last;
`endif

  assign bus.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = head_data;
  assign bus.out_last  = head_last;

  // abort outranks both a same-cycle command and a same-cycle transfer.
  assign accept = bus.cmd_valid && bus.cmd_ready && !abort;
  assign pop    = bus.out_valid && bus.out_ready && !abort;

  // Occupancy plus in-flight, net of the byte leaving this cycle. Counting the
  // departing byte as free is what lets a new read go out every cycle while
  // out_ready is held high.
  assign level       = count + {1'b0, inflight} - {1'b0, pop};
  assign room        = (level < FIFO_DEPTH);
  assign buf_rd_en_0 = (state == S_FETCH) && room && !abort;

  // Nothing in flight and the FIFO empties at the coming edge.
  assign drain_done  = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

`ifdef USB_EP_BUF_RDR_CRC_EN
  assign crc_out = ~crc_q;

  usb_crc16 u_crc16 (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (accept),
    .en    (inflight && !abort),
    .data  (buf_rd_data_1),
    .crc   (crc_q)
  );
`endif

  // FIFO write source: returning buffer data, or the CRC bytes at the tail.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    push      = inflight && !abort;
    push_data = buf_rd_data_1;
`ifdef USB_EP_BUF_RDR_CRC_EN
    push_last = 1'b0;
    if (!abort && room) begin
      if (state == S_CRC0) begin
        push      = 1'b1;
        push_data = crc_out[7:0];
      end else if ((state == S_CRC1) && !tail_pushed) begin
        push      = 1'b1;
        push_data = crc_out[15:8];
        push_last = 1'b1;
      end
    end
`else
    push_last = inflight_last;
`endif
  end

  // Control FSM and read address generation.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    if (!rst_n) begin
      state         <= S_IDLE;
      rem           <= '0;
      inflight      <= 1'b0;
      buf_rd_addr_0 <= '0;
`ifdef USB_EP_BUF_RDR_CRC_EN
      tail_pushed   <= 1'b0;
`else
      inflight_last <= 1'b0;
`endif
    end else if (abort) begin
      state         <= S_IDLE;
      inflight      <= 1'b0;
`ifdef USB_EP_BUF_RDR_CRC_EN
      tail_pushed   <= 1'b0;
`else
      inflight_last <= 1'b0;
`endif
    end else begin
      inflight <= buf_rd_en_0;
`ifndef USB_EP_BUF_RDR_CRC_EN
      inflight_last <= buf_rd_en_0 && (rem == LWIDTH'(1));
`endif
      if (buf_rd_en_0) begin
        buf_rd_addr_0 <= buf_rd_addr_0 + AWIDTH'(1);
        rem           <= rem - LWIDTH'(1);
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            buf_rd_addr_0 <= bus.cmd_addr;
            rem           <= bus.cmd_len;
            state         <= (bus.cmd_len == '0) ? S_DRAIN : S_FETCH;
          end
        end
        S_FETCH: begin
          if (buf_rd_en_0 && (rem == LWIDTH'(1))) state <= S_DRAIN;
        end
`ifdef USB_EP_BUF_RDR_CRC_EN
        // The last payload byte lands during this one cycle, so the CRC
        // register is final by the time CRC0 drives it.
        S_DRAIN: state <= S_CRC0;
        S_CRC0: begin
          if (push) state <= S_CRC1;
        end
        S_CRC1: begin
          if (push) tail_pushed <= 1'b1;
          if (tail_pushed && drain_done) begin
            tail_pushed <= 1'b0;
            state       <= S_IDLE;
          end
        end
`else
        S_DRAIN: begin
          if (drain_done) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // 2-entry shift FIFO; the head register drives out_data/out_last directly.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the FIFO storage is reset because the head is a visible output that
    // must read 0x00 out of reset; larger buffers would normally stay unreset.
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= 8'h00;
      head_last <= 1'b0;
      tail_data <= 8'h00;
      tail_last <= 1'b0;
    end else if (abort) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ep_buf_rdr.sv
// Self-checking bench for usb_ep_buf_rdr. Works with and without
// USB_EP_BUF_RDR_CRC_EN; the expected stream is built from the buffer
// contents plus a bit-serial USB CRC16 when the macro is defined.
module tb_usb_ep_buf_rdr;

  localparam int AW = 11;
  localparam int LW = 11;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] buf_rd_addr_0;
  logic          buf_rd_en_0;
  logic [7:0]    buf_rd_data_1;
  logic          abort;
  logic          busy;

  usb_ep_buf_rdr_if #(.AWIDTH(AW), .LWIDTH(LW)) bus ();

  usb_ep_buf_rdr #(.AWIDTH(AW), .LWIDTH(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .buf_rd_addr_0 (buf_rd_addr_0),
    .buf_rd_en_0   (buf_rd_en_0),
    .buf_rd_data_1 (buf_rd_data_1),
    .abort         (abort),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Endpoint buffer: synchronous read, data one cycle after the request.
  logic [7:0] mem [0:2047];
  always @(posedge clk) if (buf_rd_en_0) buf_rd_data_1 <= mem[buf_rd_addr_0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [7:0]    got_q[$];
  bit            got_last_q[$];
  logic [AW-1:0] rd_q[$];
  int issued, popped, flow_viol, stab_viol;
  int first_valid_cyc, last_pop_cyc, accept_cyc;
  bit first_seen;
  bit prev_valid, prev_ready, prev_abort, prev_last;
  logic [7:0] prev_data;

  // Stimulus/out_ready control
  int ready_pct = 100;
  bit manual = 0;

  // Expected stream
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (!manual) bus.out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Sample everything on the falling edge.
  initial forever begin
    bit pop_now;
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      pop_now = bus.out_valid && bus.out_ready && !abort;
      if (prev_valid && !prev_ready && !prev_abort &&
          (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        stab_viol++;
      if (buf_rd_en_0) begin
        if (issued - popped - int'(pop_now) >= 2) flow_viol++;
        rd_q.push_back(buf_rd_addr_0);
        issued++;
      end
      if (bus.out_valid && !first_seen) begin
        first_seen      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (pop_now) begin
        got_q.push_back(bus.out_data);
        got_last_q.push_back(bus.out_last);
        popped++;
        last_pop_cyc = cyc;
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_abort = abort;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    got_last_q.delete();
    rd_q.delete();
    issued = 0; popped = 0; flow_viol = 0; stab_viol = 0;
    first_seen = 1'b0;
  endtask

  // Reference: payload bytes from the buffer, then USB CRC16 (LSB first,
  // x^16+x^15+x^2+1, preset ones, complemented) when the feature is built in.
  task automatic build_exp(input logic [AW-1:0] addr, input int len);
    logic [15:0] crc;
    logic [7:0]  b;
    bit          fb;
    exp_q.delete();
    crc = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      b = mem[AW'(int'(addr) + i)];
      exp_q.push_back(b);
      for (int k = 0; k < 8; k++) begin
        fb  = crc[0] ^ b[k];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA001;
      end
    end
`ifdef USB_EP_BUF_RDR_CRC_EN
    crc = ~crc;
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
`endif
  endtask

  task automatic send_cmd(input string tag, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    clear_mon();
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc    = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [AW-1:0] addr, input int len);
    int n, mis;
    build_exp(addr, len);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(got_last_q[i]), 32'(i == exp_q.size() - 1));
    end
    mis = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== AW'(int'(addr) + i)) mis++;
    check({tag, "_rd_count"}, 32'(rd_q.size()), 32'(len));
    check({tag, "_rd_addr_errs"}, 32'(mis), 32'd0);
    check({tag, "_flow"}, 32'(flow_viol), 32'd0);
    check({tag, "_stable"}, 32'(stab_viol), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [AW-1:0] addr, input int len, input int pct);
    ready_pct = pct;
    send_cmd(tag, addr, LW'(len));
    wait_idle(tag, 1000);
    check_stream(tag, addr, len);
  endtask

  // Take exactly n bytes of a running packet, then hold out_ready low.
  task automatic take_n(input string tag, input int n);
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_taken"}, 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    abort         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h00);
    check("rst_rd_en",     32'(buf_rd_en_0),   32'd0);
    check("rst_rd_addr",   32'(buf_rd_addr_0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Basic read with latency
    mem[11'h010] = 8'h11; mem[11'h011] = 8'h22; mem[11'h012] = 8'h33;
    run_cmd("basic", 11'h010, 3, 100);
    check("basic_latency", 32'(first_valid_cyc - accept_cyc), 32'd2);

    // Full rate with out_ready held high
    run_cmd("rate", 11'h100, 16, 100);
    check("rate_gapless", 32'(last_pop_cyc - first_valid_cyc), 32'(exp_q.size() - 1));

    // Backpressure
    run_cmd("bp", 11'h200, 64, 50);

    // Address wrap
    mem[11'h7FF] = 8'hA5; mem[11'h000] = 8'h5A;
    run_cmd("wrap", 11'h7FF, 2, 100);
    if (rd_q.size() == 2) begin
      check("wrap_rd0", 32'(rd_q[0]), 32'h7FF);
      check("wrap_rd1", 32'(rd_q[1]), 32'h000);
    end

    // Zero-length packet
    ready_pct = 100;
    send_cmd("zlp", 11'h500, '0);
`ifndef USB_EP_BUF_RDR_CRC_EN
    @(negedge clk);
    check("zlp_busy_1cyc", 32'(busy), 32'd1);
    @(negedge clk);
    check("zlp_ready_again", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
`endif
    wait_idle("zlp", 100);
    check_stream("zlp", 11'h500, 0);

`ifdef USB_EP_BUF_RDR_CRC_EN
    // Known USB CRC16 vector
    for (int i = 0; i < 4; i++) mem[11'h300 + i] = 8'(i);
    run_cmd("crc", 11'h300, 4, 100);
    if (got_q.size() == 6) begin
      check("crc_lo", 32'(got_q[4]), 32'h5E);
      check("crc_hi", 32'(got_q[5]), 32'hF7);
      check("crc_last", 32'(got_last_q[5]), 32'd1);
    end
`endif

    // Random commands
    for (int t = 0; t < 6; t++)
      run_cmd($sformatf("rnd%0d", t), AW'($urandom_range(0, 2047)),
              $urandom_range(1, 40), $urandom_range(20, 100));

    // Abort after 5 of 20 bytes
    manual = 1'b1;
    bus.out_ready = 1'b1;
    send_cmd("abort", 11'h400, LW'(20));
    take_n("abort", 5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_rd_en",     32'(buf_rd_en_0),   32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_busy",      32'(busy),          32'd0);
    build_exp(11'h400, 20);
    check("abort_kept", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check($sformatf("abort_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    @(posedge clk);
    #1;
    manual = 1'b0;
    run_cmd("post_abort", 11'h410, 1, 100);

    // Reset mid-packet
    manual = 1'b1;
    bus.out_ready = 1'b1;
    send_cmd("midrst", 11'h600, LW'(20));
    take_n("midrst", 5);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy",      32'(busy),          32'd0);
    check("midrst_rd_en",     32'(buf_rd_en_0),   32'd0);
    check("midrst_out_data",  32'(bus.out_data),  32'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_kept", 32'(got_q.size()), 32'd5);
    @(posedge clk);
    #1;
    manual = 1'b0;
    run_cmd("post_rst", 11'h420, 1, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
